// File: rtl/rsa_priv_decrypt.sv
// -----------------------------------------------------------------------------
// rsa_priv_decrypt
//
// Private-key side of the toy RSA datapath. It derives the private exponent
// d = e^-1 mod phi with an iterative extended Euclid, one iteration per clock.
// It then decrypts m = c^d mod n by right-to-left square-and-multiply, one
// exponent bit per clock.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst_n      synchronous reset, active-low
//   start      request pulse, sampled only in IDLE
//   e_in       public exponent
//   phi_in     totient
//   n_in       modulus
//   c_in       ciphertext
//   busy       high in every state except IDLE
//   done       one-cycle pulse while results are valid (DONE state)
//   key_err    set when gcd(e,phi) != 1 or n < 2
//   priv_key   derived d, 0 on error
//   plain_out  decrypted m, 0 on error
// -----------------------------------------------------------------------------
module rsa_priv_decrypt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] e_in,
  input  logic [WIDTH-1:0] phi_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             busy,
  output logic             done,
  output logic             key_err,
  output logic [WIDTH-1:0] priv_key,
  output logic [WIDTH-1:0] plain_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EUCLID,
    S_FIXUP,
    S_EXP,
    S_DONE
  } state_t;

  // Bezout coefficients stay within +/-phi, so one extra sign bit suffices.
  typedef logic signed [WIDTH:0]     tval_t;
  // Wide enough to hold q * t exactly before truncating back to tval_t.
  typedef logic signed [2*WIDTH+1:0] twide_t;
  // Double-width operands for modular products, so nothing is lost pre-mod.
  typedef logic [2*WIDTH-1:0]        pwide_t;

  state_t           state, state_nx;

  logic [WIDTH-1:0] phi_q, phi_nx;
  logic [WIDTH-1:0] n_q, n_nx;
  logic [WIDTH-1:0] c_q, c_nx;
  logic [WIDTH-1:0] r0, r0_nx;
  logic [WIDTH-1:0] r1, r1_nx;
  tval_t            t0, t0_nx;
  tval_t            t1, t1_nx;
  logic [WIDTH-1:0] d_q, d_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] base, base_nx;
  logic [WIDTH-1:0] exp_q, exp_nx;
  logic             key_err_nx;
  logic [WIDTH-1:0] priv_key_nx;
  logic [WIDTH-1:0] plain_out_nx;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  twide_t           quot_ext;
  twide_t           t1_ext;
  tval_t            t_new;
  logic [WIDTH-1:0] d_val;
  logic             key_bad;
  pwide_t           acc_w, base_w, n_w;
  logic [WIDTH-1:0] acc_mul;
  logic [WIDTH-1:0] base_sq;
  logic [WIDTH-1:0] c_mod_n;

  // Divider outputs are only consumed while r1 != 0; the guard keeps the
  // divide-by-zero case well defined.
  assign quot     = (r1 != '0) ? r0 / r1 : '0;
  assign rem      = (r1 != '0) ? r0 % r1 : '0;

  assign quot_ext = $signed({{(WIDTH + 2){1'b0}}, quot});
  assign t1_ext   = {{(WIDTH + 1){t1[WIDTH]}}, t1};
  // The true t0 - q*t1 always fits in tval_t, so truncating the wide
  // product first gives the exact result in modular arithmetic.
  assign t_new    = t0 - tval_t'(quot_ext * t1_ext);

  // Fold a negative Bezout coefficient back into [0, phi).
  assign d_val    = WIDTH'(t0[WIDTH] ? t0 + $signed({1'b0, phi_q}) : t0);

  assign key_bad  = (r0 != WIDTH'(1)) || (n_q < WIDTH'(2));

  assign acc_w    = {{WIDTH{1'b0}}, acc};
  assign base_w   = {{WIDTH{1'b0}}, base};
  assign n_w      = {{WIDTH{1'b0}}, n_q};
  // Results of "mod n" are below n, so the upper half is always zero.
  assign acc_mul  = WIDTH'((acc_w * base_w) % n_w);
  assign base_sq  = WIDTH'((base_w * base_w) % n_w);
  assign c_mod_n  = (n_q != '0) ? c_q % n_q : '0;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_nx     = state;
    phi_nx       = phi_q;
    n_nx         = n_q;
    c_nx         = c_q;
    r0_nx        = r0;
    r1_nx        = r1;
    t0_nx        = t0;
    t1_nx        = t1;
    d_nx         = d_q;
    acc_nx       = acc;
    base_nx      = base;
    exp_nx       = exp_q;
    key_err_nx   = key_err;
    priv_key_nx  = priv_key;
    plain_out_nx = plain_out;
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);

    unique case (state)
      S_IDLE: begin
        if (start) begin
          phi_nx   = phi_in;
          n_nx     = n_in;
          c_nx     = c_in;
          r0_nx    = phi_in;
          r1_nx    = e_in;
          t0_nx    = '0;
          t1_nx    = tval_t'(1);
          state_nx = S_EUCLID;
        end
      end

      S_EUCLID: begin
        if (r1 != '0) begin
          r0_nx = r1;
          r1_nx = rem;
          t0_nx = t1;
          t1_nx = t_new;
        end else begin
          state_nx = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (key_bad) begin
          key_err_nx   = 1'b1;
          priv_key_nx  = '0;
          plain_out_nx = '0;
          state_nx     = S_DONE;
        end else begin
          d_nx     = d_val;
          acc_nx   = WIDTH'(1);
          base_nx  = c_mod_n;
          exp_nx   = d_val;
          state_nx = S_EXP;
        end
      end

      S_EXP: begin
        if (exp_q != '0) begin
          if (exp_q[0]) begin
            acc_nx = acc_mul;
          end
          base_nx = base_sq;
          exp_nx  = exp_q >> 1;
        end else begin
          key_err_nx   = 1'b0;
          priv_key_nx  = d_q;
          plain_out_nx = acc;
          state_nx     = S_DONE;
        end
      end

      S_DONE: begin
        // start is deliberately ignored here; no request is queued.
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= S_IDLE;
      phi_q     <= '0;
      n_q       <= '0;
      c_q       <= '0;
      r0        <= '0;
      r1        <= '0;
      t0        <= '0;
      t1        <= '0;
      d_q       <= '0;
      acc       <= '0;
      base      <= '0;
      exp_q     <= '0;
      key_err   <= 1'b0;
      priv_key  <= '0;
      plain_out <= '0;
    end else begin
      state     <= state_nx;
      phi_q     <= phi_nx;
      n_q       <= n_nx;
      c_q       <= c_nx;
      r0        <= r0_nx;
      r1        <= r1_nx;
      t0        <= t0_nx;
      t1        <= t1_nx;
      d_q       <= d_nx;
      acc       <= acc_nx;
      base      <= base_nx;
      exp_q     <= exp_nx;
      key_err   <= key_err_nx;
      priv_key  <= priv_key_nx;
      plain_out <= plain_out_nx;
    end
  end

endmodule
